elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 49 ++++
 rtl/door_timer.sv | 33 +++
 rtl/elevator_scheduler.sv | 158 +++++++++++++++
 tb/tb_elevator_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings and helpers for the elevator scheduler: motor codes,
// controller state enum and floor-vector utilities.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned FLOOR_W    = 2;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b01;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        DOOR  = 3'd3,
        HALT  = 3'd4,
        FAULT = 3'd5
    } state_e;

    // Index of the set bit of a one-hot floor vector (0 when none is set).
    function automatic logic [FLOOR_W-1:0] floor_idx(input logic [NUM_FLOORS-1:0] s);
        logic [FLOOR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (s[i]) idx = FLOOR_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > 32'(f));
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < 32'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/door_timer.sv
// Door dwell counter: start/restart load the first dwell cycle, done flags
// the last cycle of a dwell of DOOR_CYCLES cycles.
module door_timer #(
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_restart,
    input  logic i_run,
    output logic o_done_c
);

    localparam int unsigned       CNT_W   = 8;
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(DOOR_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start || i_restart) begin
            r_cnt <= CNT_W'(1);
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_END) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done_c = i_run && (r_cnt == CNT_END);

endmodule

// File: rtl/elevator_scheduler.sv
// Four-floor elevator controller. Define ELEV_OBSTRUCT_EN to let the door
// obstruction sensor hold the door open by restarting the dwell.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floor_sensor,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  stop_sw,
    input  logic                  door_obstruct,
    output logic [1:0]            motor,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  fault
);

    state_e                r_state;
    logic [1:0]            r_motor;
    logic                  r_door_open;
    logic [FLOOR_W-1:0]    r_cur_floor;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_fault;
    logic                  r_dir_up;

    logic                  w_sensor_valid;
    logic                  w_sensor_multi;
    logic [FLOOR_W-1:0]    w_idx;
    logic [NUM_FLOORS-1:0] w_idx_bit;
    logic [NUM_FLOORS-1:0] w_cur_bit;
    logic [NUM_FLOORS-1:0] w_req;
    logic                  w_above;
    logic                  w_below;
    logic                  w_at_call;
    logic                  w_go_fault;
    logic                  w_go_halt;
    logic                  w_to_door;
    logic                  w_door_hold;
    logic                  w_restart;
    logic                  w_done_c;

    assign w_sensor_valid = $onehot(floor_sensor);
    assign w_sensor_multi = !$onehot0(floor_sensor);
    assign w_idx          = floor_idx(floor_sensor);
    assign w_idx_bit      = NUM_FLOORS'(1) << w_idx;
    assign w_cur_bit      = NUM_FLOORS'(1) << r_cur_floor;

    // Calls for the floor whose door is open are absorbed, not latched.
    assign w_req     = r_pending | ((r_state == DOOR) ? (call_req & ~w_cur_bit) : call_req);
    assign w_above   = |(w_req & above_mask(r_cur_floor));
    assign w_below   = |(w_req & below_mask(r_cur_floor));
    assign w_at_call = w_sensor_valid && |(w_req & w_idx_bit);

    // Sensor fault outranks the emergency stop.
    assign w_go_fault = (r_state != FAULT) && w_sensor_multi;
    assign w_go_halt  = (r_state != FAULT) && !w_sensor_multi && stop_sw;
    assign w_to_door  = !w_go_fault && !w_go_halt && w_at_call &&
                        ((r_state == IDLE) || (r_state == UP) || (r_state == DOWN));

`ifdef ELEV_OBSTRUCT_EN
    assign w_door_hold = (|(call_req & w_cur_bit)) || door_obstruct;
`else
    logic w_unused_obstruct;
    assign w_unused_obstruct = door_obstruct;
    assign w_door_hold       = |(call_req & w_cur_bit);
`endif

    assign w_restart = (r_state == DOOR) && !w_go_fault && !w_go_halt && w_door_hold;

    door_timer #(
        .DOOR_CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_to_door),
        .i_restart (w_restart),
        .i_run     (r_state == DOOR),
        .o_done_c  (w_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_motor     <= MOTOR_STOP;
            r_door_open <= 1'b0;
            r_cur_floor <= '0;
            r_pending   <= '0;
            r_fault     <= 1'b0;
            r_dir_up    <= 1'b1;
        end else begin
            if (w_sensor_valid) r_cur_floor <= w_idx;
            r_pending <= w_to_door ? (w_req & ~w_idx_bit) : w_req;

            if (w_go_fault) begin
                r_state     <= FAULT;
                r_motor     <= MOTOR_STOP;
                r_door_open <= 1'b0;
                r_fault     <= 1'b1;
            end else if (w_go_halt) begin
                r_state     <= HALT;
                r_motor     <= MOTOR_STOP;
                r_door_open <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, UP, DOWN: begin
                        if (w_at_call) begin
                            r_state     <= DOOR;
                            r_motor     <= MOTOR_STOP;
                            r_door_open <= 1'b1;
                        end else if (r_state == IDLE) begin
                            // Both directions pending: keep the last travel direction.
                            if (w_above && (!w_below || r_dir_up)) begin
                                r_state  <= UP;
                                r_motor  <= MOTOR_UP;
                                r_dir_up <= 1'b1;
                            end else if (w_below) begin
                                r_state  <= DOWN;
                                r_motor  <= MOTOR_DOWN;
                                r_dir_up <= 1'b0;
                            end
                        end else if (w_sensor_valid &&
                                     (((r_state == UP) && (w_idx == FLOOR_W'(NUM_FLOORS - 1))) ||
                                      ((r_state == DOWN) && (w_idx == '0)))) begin
                            r_state <= IDLE;
                            r_motor <= MOTOR_STOP;
                        end
                    end
                    DOOR: begin
                        if (w_done_c && !w_restart) begin
                            r_state     <= IDLE;
                            r_door_open <= 1'b0;
                        end
                    end
                    HALT: begin
                        r_state <= IDLE;
                    end
                    FAULT: begin
                        r_state <= FAULT;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_motor <= MOTOR_STOP;
                    end
                endcase
            end
        end
    end

    assign motor     = r_motor;
    assign door_open = r_door_open;
    assign cur_floor = r_cur_floor;
    assign pending   = r_pending;
    assign fault     = r_fault;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: directed stimulus queues expected
// outputs tagged with the cycle they are due; a negedge monitor compares them.
module tb_elevator_scheduler;

`ifdef ELEV_OBSTRUCT_EN
    localparam logic OBS = 1'b1;
`else
    localparam logic OBS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] floor_sensor;
    logic [3:0] call_req;
    logic       stop_sw;
    logic       door_obstruct;
    logic [1:0] motor;
    logic       door_open;
    logic [1:0] cur_floor;
    logic [3:0] pending;
    logic       fault;

    elevator_scheduler #(.DOOR_CYCLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .floor_sensor  (floor_sensor),
        .call_req      (call_req),
        .stop_sw       (stop_sw),
        .door_obstruct (door_obstruct),
        .motor         (motor),
        .door_open     (door_open),
        .cur_floor     (cur_floor),
        .pending       (pending),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         when;
        logic [1:0] motor;
        logic       door;
        logic [1:0] cur;
        logic [3:0] pend;
        logic       fault;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    cyc    = 0;
    int    checks = 0;
    int    queued = 0;
    int    errors = 0;
    exp_t  mon_e;
    string mon_t;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the outputs are compared against whatever is due.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].when <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (mon_e.when != cyc ||
                {motor, door_open, cur_floor, pending, fault} !==
                {mon_e.motor, mon_e.door, mon_e.cur, mon_e.pend, mon_e.fault}) begin
                errors++;
                $display("FAIL %s @cyc %0d: got motor=%b door=%b cur=%0d pend=%b fault=%b, want motor=%b door=%b cur=%0d pend=%b fault=%b",
                         mon_t, cyc, motor, door_open, cur_floor, pending, fault,
                         mon_e.motor, mon_e.door, mon_e.cur, mon_e.pend, mon_e.fault);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the outputs expected after the next clock edge, then advance.
    task automatic step_chk(input string tag, input logic [1:0] m, input logic d,
                            input logic [1:0] c, input logic [3:0] p, input logic f);
        exp_t e;
        e.when  = cyc + 1;
        e.motor = m;
        e.door  = d;
        e.cur   = c;
        e.pend  = p;
        e.fault = f;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        queued++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, want under 20000", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; floor_sensor = 4'b0000; call_req = 4'b0000;
        stop_sw = 1'b0; door_obstruct = 1'b0;
        step_chk("reset", 2'b00, 0, 2'd0, 4'b0000, 0);

        // Floor 1 -> floor 4 trip and dwell
        rst = 1'b0; floor_sensor = 4'b0001; call_req = 4'b1000;
        step_chk("a_start", 2'b01, 0, 2'd0, 4'b1000, 0);
        call_req = 4'b0000;
        step_chk("a_leave1", 2'b01, 0, 2'd0, 4'b1000, 0);
        floor_sensor = 4'b0000; step_chk("a_between", 2'b01, 0, 2'd0, 4'b1000, 0);
        floor_sensor = 4'b0010; step_chk("a_pass2",   2'b01, 0, 2'd1, 4'b1000, 0);
        floor_sensor = 4'b0100; step_chk("a_pass3",   2'b01, 0, 2'd2, 4'b1000, 0);
        floor_sensor = 4'b1000; step_chk("a_arrive4", 2'b00, 1, 2'd3, 4'b0000, 0);
        for (int i = 0; i < 7; i++) step_chk("a_dwell", 2'b00, 1, 2'd3, 4'b0000, 0);
        step_chk("a_close", 2'b00, 0, 2'd3, 4'b0000, 0);
        step_chk("a_idle",  2'b00, 0, 2'd3, 4'b0000, 0);

        // Serve floor 4 before turning back for floor 1
        rst = 1'b1; step_chk("b_reset", 2'b00, 0, 2'd0, 4'b0000, 0);
        rst = 1'b0; floor_sensor = 4'b0001; call_req = 4'b1000;
        step_chk("b_start", 2'b01, 0, 2'd0, 4'b1000, 0);
        call_req = 4'b0000; floor_sensor = 4'b0000;
        step_chk("b_between", 2'b01, 0, 2'd0, 4'b1000, 0);
        floor_sensor = 4'b0010; call_req = 4'b0001;
        step_chk("b_floor2", 2'b01, 0, 2'd1, 4'b1001, 0);
        call_req = 4'b0000; floor_sensor = 4'b0000;
        step_chk("b_between2", 2'b01, 0, 2'd1, 4'b1001, 0);
        floor_sensor = 4'b0100; step_chk("b_pass3",  2'b01, 0, 2'd2, 4'b1001, 0);
        floor_sensor = 4'b1000; step_chk("b_serve4", 2'b00, 1, 2'd3, 4'b0001, 0);
        for (int i = 0; i < 7; i++) step_chk("b_dwell", 2'b00, 1, 2'd3, 4'b0001, 0);
        step_chk("b_close", 2'b00, 0, 2'd3, 4'b0001, 0);
        step_chk("b_down",  2'b10, 0, 2'd3, 4'b0001, 0);
        floor_sensor = 4'b0000; step_chk("b_leave4", 2'b10, 0, 2'd3, 4'b0001, 0);
        floor_sensor = 4'b0100; step_chk("b_pass3d", 2'b10, 0, 2'd2, 4'b0001, 0);
        floor_sensor = 4'b0010; step_chk("b_pass2d", 2'b10, 0, 2'd1, 4'b0001, 0);
        floor_sensor = 4'b0001; step_chk("b_serve1", 2'b00, 1, 2'd0, 4'b0000, 0);
        step_chk("b_dwell1", 2'b00, 1, 2'd0, 4'b0000, 0);
        rst = 1'b1; step_chk("b_rst_dwell", 2'b00, 0, 2'd0, 4'b0000, 0);

        // Call at the idle floor opens the door; same-floor call restarts dwell
        rst = 1'b0; floor_sensor = 4'b0100;
        step_chk("c_idle3", 2'b00, 0, 2'd2, 4'b0000, 0);
        call_req = 4'b0100; step_chk("c_door",  2'b00, 1, 2'd2, 4'b0000, 0);
        call_req = 4'b1000; step_chk("c_other", 2'b00, 1, 2'd2, 4'b1000, 0);
        call_req = 4'b0000;
        for (int i = 0; i < 2; i++) step_chk("c_dwell", 2'b00, 1, 2'd2, 4'b1000, 0);
        call_req = 4'b0100; step_chk("c_callcur", 2'b00, 1, 2'd2, 4'b1000, 0);
        call_req = 4'b0000;
        for (int i = 0; i < 7; i++) step_chk("c_extend", 2'b00, 1, 2'd2, 4'b1000, 0);
        step_chk("c_close",  2'b00, 0, 2'd2, 4'b1000, 0);
        step_chk("c_resume", 2'b01, 0, 2'd2, 4'b1000, 0);
        floor_sensor = 4'b0000; rst = 1'b1;
        step_chk("c_rst_move", 2'b00, 0, 2'd0, 4'b0000, 0);

        // Emergency stop between floors, call latched while halted
        rst = 1'b0; floor_sensor = 4'b0001; call_req = 4'b0100;
        step_chk("d_start", 2'b01, 0, 2'd0, 4'b0100, 0);
        call_req = 4'b0000; floor_sensor = 4'b0000;
        step_chk("d_move", 2'b01, 0, 2'd0, 4'b0100, 0);
        stop_sw = 1'b1;     step_chk("d_halt",  2'b00, 0, 2'd0, 4'b0100, 0);
        call_req = 4'b0010; step_chk("d_latch", 2'b00, 0, 2'd0, 4'b0110, 0);
        call_req = 4'b0000; step_chk("d_hold",  2'b00, 0, 2'd0, 4'b0110, 0);
        stop_sw = 1'b0;     step_chk("d_release", 2'b00, 0, 2'd0, 4'b0110, 0);
        step_chk("d_resume", 2'b01, 0, 2'd0, 4'b0110, 0);
        floor_sensor = 4'b0010; step_chk("d_serve2", 2'b00, 1, 2'd1, 4'b0100, 0);
        rst = 1'b1; step_chk("d_reset", 2'b00, 0, 2'd0, 4'b0000, 0);

        // End-stop at the top floor with nothing pending there
        rst = 1'b0; floor_sensor = 4'b0001; call_req = 4'b0100;
        step_chk("g_start", 2'b01, 0, 2'd0, 4'b0100, 0);
        call_req = 4'b0000; floor_sensor = 4'b0010;
        step_chk("g_pass2", 2'b01, 0, 2'd1, 4'b0100, 0);
        floor_sensor = 4'b1000; step_chk("g_endstop", 2'b00, 0, 2'd3, 4'b0100, 0);
        step_chk("g_back", 2'b10, 0, 2'd3, 4'b0100, 0);
        rst = 1'b1; step_chk("g_reset", 2'b00, 0, 2'd0, 4'b0000, 0);

        // Multi-bit sensor with stop_sw in the same cycle resolves to FAULT
        rst = 1'b0; floor_sensor = 4'b0001; call_req = 4'b1000;
        step_chk("e_start", 2'b01, 0, 2'd0, 4'b1000, 0);
        call_req = 4'b0000; floor_sensor = 4'b0110; stop_sw = 1'b1;
        step_chk("e_fault", 2'b00, 0, 2'd0, 4'b1000, 1);
        floor_sensor = 4'b0001; stop_sw = 1'b0;
        step_chk("e_hold", 2'b00, 0, 2'd0, 4'b1000, 1);
        stop_sw = 1'b1; step_chk("e_hold_stop", 2'b00, 0, 2'd0, 4'b1000, 1);
        stop_sw = 1'b0; rst = 1'b1;
        step_chk("e_reset", 2'b00, 0, 2'd0, 4'b0000, 0);

        // Door obstruction for 5 cycles mid-dwell
        rst = 1'b0; call_req = 4'b0001;
        step_chk("f_door", 2'b00, 1, 2'd0, 4'b0000, 0);
        call_req = 4'b0000;
        for (int i = 0; i < 2; i++) step_chk("f_dwell", 2'b00, 1, 2'd0, 4'b0000, 0);
        door_obstruct = 1'b1;
        for (int i = 0; i < 5; i++) step_chk("f_obstructed", 2'b00, 1, 2'd0, 4'b0000, 0);
        door_obstruct = 1'b0;
        step_chk("f_e8", 2'b00, OBS, 2'd0, 4'b0000, 0);
        for (int i = 0; i < 6; i++) step_chk("f_ext", 2'b00, OBS, 2'd0, 4'b0000, 0);
        step_chk("f_e15", 2'b00, 0, 2'd0, 4'b0000, 0);

        step();
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left unchecked, want 0", exp_q.size());
        end
        if (checks != queued) begin
            errors++;
            $display("FAIL coverage: got %0d checks, want %0d", checks, queued);
        end
        if (errors != 0) begin
            $display("FAIL summary: got %0d errors, want 0", errors);
        end else begin
            $display("PASS");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
